// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver. It hunts for SYNC_BYTE, collects a
// length-prefixed payload, checks the additive checksum and streams out frames that pass.
//
// Output handshake: a byte moves when out_valid && out_ready are both high at a rising
// edge. out_valid stays high and out_data/out_last stay stable until that byte is taken.
module uart_rx_frame_ctrl #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         MAX_LEN        = 16,
   parameter int         TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       busy,
   output logic       err_chk,
   output logic       err_len,
   output logic       err_timeout,
   output logic       err_overrun,
   output logic [2:0] state_dbg
);

   localparam int PW = $clog2(MAX_LEN + 1);
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

   state_t        state, state_d;
   logic [PW-1:0] len, len_d, wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d;
   logic [7:0]    sum, sum_d;
   logic [TW-1:0] cnt, cnt_d;
   logic          err_chk_d, err_len_d, err_timeout_d, err_overrun_d;
   logic          wr_en, timed, last_rd;
   logic [7:0]    buffer [MAX_LEN];

   assign timed   = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
   assign last_rd = (rd_ptr == len - PW'(1));

   always_comb begin
      state_d       = state;
      len_d         = len;
      wr_ptr_d      = wr_ptr;
      rd_ptr_d      = rd_ptr;
      sum_d         = sum;
      cnt_d         = '0;
      err_chk_d     = 1'b0;
      err_len_d     = 1'b0;
      err_timeout_d = 1'b0;
      err_overrun_d = 1'b0;
      wr_en         = 1'b0;
      if (timed && !rx_done) cnt_d = cnt + TW'(1);
      case (state)
         S_IDLE: begin
            if (rx_done && rx_data == SYNC_BYTE) state_d = S_LEN;
         end
         S_LEN: begin
            if (rx_done) begin
               if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                  err_len_d = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  len_d    = PW'(rx_data);
                  sum_d    = rx_data;
                  wr_ptr_d = '0;
                  state_d  = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (rx_done) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr + PW'(1);
               sum_d    = sum + rx_data;
               if (wr_ptr == len - PW'(1)) state_d = S_CHK;
            end
         end
         S_CHK: begin
            if (rx_done) begin
               if (rx_data == sum) begin
                  rd_ptr_d = '0;
                  state_d  = S_DRAIN;
               end else begin
                  err_chk_d = 1'b1;
                  state_d   = S_IDLE;
               end
            end
         end
         S_DRAIN: begin
            if (out_ready) begin
               rd_ptr_d = rd_ptr + PW'(1);
               if (last_rd) state_d = S_IDLE;
            end
            // Bytes arriving while draining are dropped, sync bytes included.
            if (rx_done) err_overrun_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      // A strobe on the expiry edge wins, hence the !rx_done qualifier.
      if (timed && !rx_done && cnt == TO_LAST) begin
         err_timeout_d = 1'b1;
         cnt_d         = '0;
         state_d       = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         len         <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         sum         <= '0;
         cnt         <= '0;
         err_chk     <= 1'b0;
         err_len     <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         state       <= state_d;
         len         <= len_d;
         wr_ptr      <= wr_ptr_d;
         rd_ptr      <= rd_ptr_d;
         sum         <= sum_d;
         cnt         <= cnt_d;
         err_chk     <= err_chk_d;
         err_len     <= err_len_d;
         err_timeout <= err_timeout_d;
         err_overrun <= err_overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) buffer[wr_ptr[AW-1:0]] <= rx_data;
   end

   assign out_valid = (state == S_DRAIN);
   assign out_data  = out_valid ? buffer[rd_ptr[AW-1:0]] : 8'd0;
   assign out_last  = out_valid && last_rd;
   assign busy      = (state != S_IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: per-cycle vector table, hand sequences for timeout and
// reset, and a payload scoreboard fed by the expected byte order of every good frame.
module tb_uart_rx_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'd0;
   logic       rx_done = 1'b0;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
   logic       out_valid, out_last, busy;
   logic       err_chk, err_len, err_timeout, err_overrun;
   logic [2:0] state_dbg;

   int n_tests = 0;
   int n_fail  = 0;

   // {valid, data, last, busy, err_chk, err_len, err_timeout, err_overrun}
   typedef struct {
      logic        rx_done;
      logic [7:0]  rx_data;
      logic        out_ready;
      logic [14:0] exp;
   } vec_t;

   vec_t       vec_q[$];
   logic [7:0] exp_q[$];

   uart_rx_frame_ctrl dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .err_chk(err_chk), .err_len(err_len),
      .err_timeout(err_timeout), .err_overrun(err_overrun), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [14:0] outs();
      return {out_valid, out_data, out_last, busy, err_chk, err_len, err_timeout, err_overrun};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic d, input logic [7:0] b, input logic rdy, input logic v,
                      input logic [7:0] od, input logic l, input logic bz, input logic [3:0] e);
      vec_t t;
      t.rx_done = d; t.rx_data = b; t.out_ready = rdy; t.exp = {v, od, l, bz, e};
      vec_q.push_back(t);
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         rx_done   = vec_q[i].rx_done;
         rx_data   = vec_q[i].rx_data;
         out_ready = vec_q[i].out_ready;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), 32'(outs()), 32'(vec_q[i].exp));
      end
      rx_done = 1'b0;
   endtask

   task automatic step(input logic d, input logic [7:0] b);
      rx_done = d;
      rx_data = b;
      @(posedge clk);
      #1;
      rx_done = 1'b0;
   endtask

   // Scoreboard: every accepted output byte must match the next expected payload byte.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_extra: got %h expected no transfer", out_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               n_fail++;
               $display("FAIL sb_byte: got %h expected %h", out_data, e);
            end
         end
      end
   end

   initial begin
      int seg_a, seg_b, first_to, n_pulse;
      logic seen;

      // Good frame, out_ready high
      add(1,8'hA5,1, 0,8'h00,0,1,4'b0000);
      add(1,8'h03,1, 0,8'h00,0,1,4'b0000);
      add(1,8'h11,1, 0,8'h00,0,1,4'b0000);
      add(1,8'h22,1, 0,8'h00,0,1,4'b0000);
      add(1,8'h33,1, 0,8'h00,0,1,4'b0000);
      add(1,8'h69,1, 1,8'h11,0,1,4'b0000);
      add(0,8'h00,1, 1,8'h22,0,1,4'b0000);
      add(0,8'h00,1, 1,8'h33,1,1,4'b0000);
      add(0,8'h00,1, 0,8'h00,0,0,4'b0000);
      // Bad checksum
      add(1,8'hA5,1, 0,8'h00,0,1,4'b0000);
      add(1,8'h02,1, 0,8'h00,0,1,4'b0000);
      add(1,8'h10,1, 0,8'h00,0,1,4'b0000);
      add(1,8'h20,1, 0,8'h00,0,1,4'b0000);
      add(1,8'h00,1, 0,8'h00,0,0,4'b1000);
      add(0,8'h00,1, 0,8'h00,0,0,4'b0000);
      // Length 0, then a sync in the pulse cycle, then length 0x11
      add(1,8'hA5,1, 0,8'h00,0,1,4'b0000);
      add(1,8'h00,1, 0,8'h00,0,0,4'b0100);
      add(1,8'hA5,1, 0,8'h00,0,1,4'b0000);
      add(1,8'h11,1, 0,8'h00,0,0,4'b0100);
      add(0,8'h00,1, 0,8'h00,0,0,4'b0000);
      // Garbage then a one-byte frame
      add(1,8'h00,1, 0,8'h00,0,0,4'b0000);
      add(1,8'hFF,1, 0,8'h00,0,0,4'b0000);
      add(1,8'hA5,1, 0,8'h00,0,1,4'b0000);
      add(1,8'h01,1, 0,8'h00,0,1,4'b0000);
      add(1,8'h7E,1, 0,8'h00,0,1,4'b0000);
      add(1,8'h7F,1, 1,8'h7E,1,1,4'b0000);
      add(0,8'h00,1, 0,8'h00,0,0,4'b0000);
      // Backpressure for 5 cycles with overruns, then drain
      add(1,8'hA5,0, 0,8'h00,0,1,4'b0000);
      add(1,8'h02,0, 0,8'h00,0,1,4'b0000);
      add(1,8'hAA,0, 0,8'h00,0,1,4'b0000);
      add(1,8'hBB,0, 0,8'h00,0,1,4'b0000);
      add(1,8'h67,0, 1,8'hAA,0,1,4'b0000);
      add(0,8'h00,0, 1,8'hAA,0,1,4'b0000);
      add(0,8'h00,0, 1,8'hAA,0,1,4'b0000);
      add(1,8'h55,0, 1,8'hAA,0,1,4'b0001);
      add(1,8'hA5,0, 1,8'hAA,0,1,4'b0001);
      add(0,8'h00,0, 1,8'hAA,0,1,4'b0000);
      add(0,8'h00,1, 1,8'hBB,1,1,4'b0000);
      add(1,8'hC3,1, 0,8'h00,0,0,4'b0001);
      add(0,8'h00,1, 0,8'h00,0,0,4'b0000);
      seg_a = vec_q.size();
      // Good frame after reset
      add(1,8'hA5,1, 0,8'h00,0,1,4'b0000);
      add(1,8'h03,1, 0,8'h00,0,1,4'b0000);
      add(1,8'h11,1, 0,8'h00,0,1,4'b0000);
      add(1,8'h22,1, 0,8'h00,0,1,4'b0000);
      add(1,8'h33,1, 0,8'h00,0,1,4'b0000);
      add(1,8'h69,1, 1,8'h11,0,1,4'b0000);
      add(0,8'h00,1, 1,8'h22,0,1,4'b0000);
      add(0,8'h00,1, 1,8'h33,1,1,4'b0000);
      add(0,8'h00,1, 0,8'h00,0,0,4'b0000);
      seg_b = vec_q.size();

      exp_q = '{8'h11, 8'h22, 8'h33, 8'h7E, 8'hAA, 8'hBB,
                8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h22, 8'h33};

      // Reset state
      #12;
      check("reset_outs", 32'({outs(), state_dbg}), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_vecs(0, seg_a);

      // Timeout after A5,04,01
      step(1, 8'hA5);
      step(1, 8'h04);
      step(1, 8'h01);
      first_to = -1;
      n_pulse  = 0;
      seen     = 1'b0;
      for (int k = 1; k <= 1010; k++) begin
         step(0, 8'h00);
         if (err_timeout) begin
            n_pulse++;
            if (!seen) begin
               seen     = 1'b1;
               first_to = k;
               check("timeout_idle", 32'({busy, state_dbg}), 32'd0);
            end
         end
      end
      check("timeout_cycle", 32'(first_to), 32'd1000);
      check("timeout_pulses", 32'(n_pulse), 32'd1);

      // A strobe on the expiry edge keeps the frame alive
      step(1, 8'hA5);
      step(1, 8'h04);
      seen = 1'b0;
      for (int k = 1; k <= 999; k++) begin
         step(0, 8'h00);
         if (err_timeout) seen = 1'b1;
      end
      step(1, 8'h01);
      check("prio_no_timeout", 32'({seen, err_timeout, busy}), 32'b001);
      step(1, 8'h02);
      step(1, 8'h03);
      step(1, 8'h04);
      step(1, 8'h0E);
      check("prio_valid", 32'({out_valid, out_data}), 32'h101);
      repeat (4) step(0, 8'h00);
      check("prio_done", 32'({out_valid, busy}), 32'd0);

      // Reset mid-payload
      step(1, 8'hA5);
      step(1, 8'h03);
      step(1, 8'h11);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset", 32'({outs(), state_dbg}), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("reset_held", 32'({outs(), state_dbg}), 32'd0);

      run_vecs(seg_a, seg_b);
      step(0, 8'h00);

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
